// File: rtl/svarog_trace_pkg.sv
// Shared definitions for the Svarog instruction trace buffer.
// Build option: SVAROG_TRACE_MEM_EN adds the RAM access fields (flags,
// address, data) to every stored entry.
package svarog_trace_pkg;

    typedef enum logic [1:0] {
        TR_IDLE = 2'b00,
        TR_PRE  = 2'b01,
        TR_POST = 2'b10,
        TR_DONE = 2'b11
    } tr_state_e;

    localparam int TR_FLAG_RD = 0;
    localparam int TR_FLAG_WR = 1;

    // Entry layout, LSB first: pc | instr | flags | ram addr | ram data.
    // Without the memory fields an entry is just pc | instr.
    function automatic int tr_entry_w(input int xlen);
`ifdef SVAROG_TRACE_MEM_EN
        return xlen + 32 + 2 + 2 * xlen;
`else
        return xlen + 32;
`endif
    endfunction

endpackage

// File: rtl/svarog_trace_ram.sv
// Simple dual-port trace storage: one write port, one synchronous read port.
// A read of the entry being written in the same cycle returns the old data.
module svarog_trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write and registered read share the edge; the read sees pre-write contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/svarog_trace_buffer.sv
// Svarog RV32 instruction trace recorder. Captures retired instructions into
// a circular buffer, stops a programmable number of entries after a PC match
// and offers a one-cycle-latency read port indexed from the oldest entry.
// Build option: SVAROG_TRACE_MEM_EN stores RAM flags/address/data per entry;
// otherwise rd_flags_o, rd_mem_addr_o and rd_mem_data_o are tied to 0.
//
// state   | meaning
// --------+-------------------------------------------
// TR_IDLE | no capture, buffer untouched
// TR_PRE  | capturing, waiting for trigger PC
// TR_POST | capturing, remaining entries counting down
// TR_DONE | frozen, buffer holds the final trace
module svarog_trace_buffer
    import svarog_trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             retire_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [31:0]      instr_i,
    input  logic             ram_wr_en_i,
    input  logic             ram_rd_en_i,
    input  logic [XLEN-1:0]  ram_addr_i,
    input  logic [XLEN-1:0]  ram_data_i,
    input  logic             arm_i,
    input  logic             trig_en_i,
    input  logic [XLEN-1:0]  trig_pc_i,
    input  logic [CNT_W-1:0] post_count_i,
    input  logic [AW-1:0]    rd_idx_i,
    output logic [XLEN-1:0]  rd_pc_o,
    output logic [31:0]      rd_instr_o,
    output logic [1:0]       rd_flags_o,
    output logic [XLEN-1:0]  rd_mem_addr_o,
    output logic [XLEN-1:0]  rd_mem_data_o,
    output logic [1:0]       state_o,
    output logic [CW-1:0]    count_o,
    output logic             done_o
);

    localparam int EW        = tr_entry_w(XLEN);
    localparam int INSTR_LSB = XLEN;

    tr_state_e        state;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] remaining;
    logic             rd_valid;

    logic             capturing;
    logic             we;
    logic             trig_hit;
    logic [AW-1:0]    rd_addr;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;

    assign capturing = (state == TR_PRE) || (state == TR_POST);
    // arm_i restarts the buffer, so a retire in the same cycle is dropped.
    assign we        = retire_i && capturing && !arm_i;
    assign trig_hit  = (state == TR_PRE) && trig_en_i && retire_i && (pc_i == trig_pc_i);
    // Oldest valid entry sits count slots behind the write pointer.
    assign rd_addr   = wr_ptr - count[AW-1:0] + rd_idx_i;

    // Capture FSM, write pointer, fill count and post-trigger down-counter.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= TR_IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
        end else if (arm_i) begin
            state     <= TR_PRE;
            wr_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
        end else if (we) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
            case (state)
                TR_PRE: begin
                    if (trig_hit) begin
                        if (post_count_i == '0) begin
                            state <= TR_DONE;
                        end else begin
                            state     <= TR_POST;
                            remaining <= post_count_i;
                        end
                    end
                end
                TR_POST: begin
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= TR_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Remember whether the sampled read index addressed a valid entry.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= ({1'b0, rd_idx_i} < count);
        end
    end

    svarog_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (wr_ptr),
        .wdata_i (wdata),
        .raddr_i (rd_addr),
        .rdata_o (rdata)
    );

    assign rd_pc_o    = rd_valid ? rdata[XLEN-1:0] : '0;
    assign rd_instr_o = rd_valid ? rdata[INSTR_LSB +: 32] : '0;

`ifdef SVAROG_TRACE_MEM_EN
    localparam int FLAG_LSB = XLEN + 32;
    localparam int ADDR_LSB = XLEN + 34;
    localparam int DATA_LSB = 2 * XLEN + 34;

    logic [1:0] wflags;

    assign wflags[TR_FLAG_WR] = ram_wr_en_i;
    assign wflags[TR_FLAG_RD] = ram_rd_en_i;
    assign wdata = {ram_data_i, ram_addr_i, wflags, instr_i, pc_i};

    assign rd_flags_o    = rd_valid ? rdata[FLAG_LSB +: 2] : '0;
    assign rd_mem_addr_o = rd_valid ? rdata[ADDR_LSB +: XLEN] : '0;
    assign rd_mem_data_o = rd_valid ? rdata[DATA_LSB +: XLEN] : '0;
`else
    logic unused_mem;

    assign unused_mem    = ^{ram_wr_en_i, ram_rd_en_i, ram_addr_i, ram_data_i};
    assign wdata         = {instr_i, pc_i};
    assign rd_flags_o    = '0;
    assign rd_mem_addr_o = '0;
    assign rd_mem_data_o = '0;
`endif

    assign state_o = state;
    assign count_o = count;
    assign done_o  = (state == TR_DONE);

endmodule

// File: tb/tb_svarog_trace_buffer.sv
// Directed bench for svarog_trace_buffer (DEPTH=64, XLEN=32, CNT_W=16).
module tb_svarog_trace_buffer;

    localparam int DEPTH = 64;
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam int AW    = 6;

    logic             clk_i = 1'b0;
    logic             reset_ni;
    logic             retire_i;
    logic [XLEN-1:0]  pc_i;
    logic [31:0]      instr_i;
    logic             ram_wr_en_i;
    logic             ram_rd_en_i;
    logic [XLEN-1:0]  ram_addr_i;
    logic [XLEN-1:0]  ram_data_i;
    logic             arm_i;
    logic             trig_en_i;
    logic [XLEN-1:0]  trig_pc_i;
    logic [CNT_W-1:0] post_count_i;
    logic [AW-1:0]    rd_idx_i;
    logic [XLEN-1:0]  rd_pc_o;
    logic [31:0]      rd_instr_o;
    logic [1:0]       rd_flags_o;
    logic [XLEN-1:0]  rd_mem_addr_o;
    logic [XLEN-1:0]  rd_mem_data_o;
    logic [1:0]       state_o;
    logic [AW:0]      count_o;
    logic             done_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] idx;
        logic          valid;
        logic [31:0]   pc;
    } rd_vec_t;

    rd_vec_t basic_tbl[5];
    rd_vec_t wrap_tbl[5];

    svarog_trace_buffer #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .retire_i      (retire_i),
        .pc_i          (pc_i),
        .instr_i       (instr_i),
        .ram_wr_en_i   (ram_wr_en_i),
        .ram_rd_en_i   (ram_rd_en_i),
        .ram_addr_i    (ram_addr_i),
        .ram_data_i    (ram_data_i),
        .arm_i         (arm_i),
        .trig_en_i     (trig_en_i),
        .trig_pc_i     (trig_pc_i),
        .post_count_i  (post_count_i),
        .rd_idx_i      (rd_idx_i),
        .rd_pc_o       (rd_pc_o),
        .rd_instr_o    (rd_instr_o),
        .rd_flags_o    (rd_flags_o),
        .rd_mem_addr_o (rd_mem_addr_o),
        .rd_mem_data_o (rd_mem_data_o),
        .state_o       (state_o),
        .count_o       (count_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic retire_mem(input logic [31:0] pc, input logic wr, input logic rd,
                              input logic [31:0] addr, input logic [31:0] data);
        pc_i        = pc;
        instr_i     = instr_of(pc);
        ram_wr_en_i = wr;
        ram_rd_en_i = rd;
        ram_addr_i  = addr;
        ram_data_i  = data;
        retire_i    = 1'b1;
        tick();
        retire_i    = 1'b0;
        ram_wr_en_i = 1'b0;
        ram_rd_en_i = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc);
        retire_mem(pc, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic read_entry(input string name, input logic [AW-1:0] idx,
                              input logic valid, input logic [31:0] pc);
        rd_idx_i = idx;
        tick();
        check({name, "_pc"}, rd_pc_o, valid ? pc : 32'h0);
        check({name, "_instr"}, rd_instr_o, valid ? instr_of(pc) : 32'h0);
    endtask

    initial begin
        basic_tbl[0] = '{idx: 6'd0,  valid: 1'b1, pc: 32'h00};
        basic_tbl[1] = '{idx: 6'd2,  valid: 1'b1, pc: 32'h08};
        basic_tbl[2] = '{idx: 6'd4,  valid: 1'b1, pc: 32'h10};
        basic_tbl[3] = '{idx: 6'd5,  valid: 1'b0, pc: 32'h00};
        basic_tbl[4] = '{idx: 6'd63, valid: 1'b0, pc: 32'h00};

        wrap_tbl[0] = '{idx: 6'd0,  valid: 1'b1, pc: 32'h018};
        wrap_tbl[1] = '{idx: 6'd1,  valid: 1'b1, pc: 32'h01C};
        wrap_tbl[2] = '{idx: 6'd31, valid: 1'b1, pc: 32'h094};
        wrap_tbl[3] = '{idx: 6'd62, valid: 1'b1, pc: 32'h110};
        wrap_tbl[4] = '{idx: 6'd63, valid: 1'b1, pc: 32'h114};

        reset_ni     = 1'b0;
        retire_i     = 1'b0;
        pc_i         = '0;
        instr_i      = '0;
        ram_wr_en_i  = 1'b0;
        ram_rd_en_i  = 1'b0;
        ram_addr_i   = '0;
        ram_data_i   = '0;
        arm_i        = 1'b0;
        trig_en_i    = 1'b0;
        trig_pc_i    = '0;
        post_count_i = '0;
        rd_idx_i     = '0;

        repeat (2) tick();
        check("rst_state", state_o, 2'b00);
        check("rst_count", count_o, 7'd0);
        check("rst_done", done_o, 1'b0);
        check("rst_rd_pc", rd_pc_o, 32'h0);
        reset_ni = 1'b1;
        tick();

        // Retires while idle are not recorded.
        retire(32'h40);
        check("idle_count", count_o, 7'd0);
        check("idle_state", state_o, 2'b00);

        // Five retires, trigger PC present but trigger disabled.
        trig_pc_i = 32'h08;
        trig_en_i = 1'b0;
        arm();
        for (int i = 0; i < 5; i++) retire(32'(4 * i));
        check("basic_state", state_o, 2'b01);
        check("basic_count", count_o, 7'd5);
        check("basic_done", done_o, 1'b0);
        for (int i = 0; i < 5; i++)
            read_entry($sformatf("basic%0d", i), basic_tbl[i].idx, basic_tbl[i].valid, basic_tbl[i].pc);

        // Wrap: 70 retires into 64 slots.
        arm();
        for (int i = 0; i < 70; i++) retire(32'(4 * i));
        check("wrap_count", count_o, 7'd64);
        for (int i = 0; i < 5; i++)
            read_entry($sformatf("wrap%0d", i), wrap_tbl[i].idx, wrap_tbl[i].valid, wrap_tbl[i].pc);

        // Read of the oldest slot while it is overwritten returns the old entry.
        rd_idx_i = 6'd0;
        pc_i     = 32'h118;
        instr_i  = instr_of(32'h118);
        retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
        check("rdw_old_pc", rd_pc_o, 32'h18);
        read_entry("rdw_oldest", 6'd0, 1'b1, 32'h1C);
        read_entry("rdw_newest", 6'd63, 1'b1, 32'h118);

        // Trigger at 0x20 with three post-trigger entries.
        trig_pc_i    = 32'h20;
        trig_en_i    = 1'b1;
        post_count_i = 16'd3;
        arm();
        for (int i = 0; i <= 16; i++) begin
            retire(32'(4 * i));
            if (i == 8) check("trig_post_state", state_o, 2'b10);
        end
        check("trig_state", state_o, 2'b11);
        check("trig_done", done_o, 1'b1);
        check("trig_count", count_o, 7'd12);
        read_entry("trig_newest", 6'd11, 1'b1, 32'h2C);
        read_entry("trig_oldest", 6'd0, 1'b1, 32'h00);
        read_entry("trig_beyond", 6'd12, 1'b0, 32'h00);

        // Zero post count: done on the trigger store itself.
        trig_pc_i    = 32'h08;
        post_count_i = 16'd0;
        arm();
        retire(32'h00);
        retire(32'h04);
        retire(32'h08);
        check("post0_state", state_o, 2'b11);
        check("post0_count", count_o, 7'd3);
        retire(32'h0C);
        check("post0_frozen", count_o, 7'd3);
        read_entry("post0_newest", 6'd2, 1'b1, 32'h08);

        // Arm and retire together: the retire is dropped.
        pc_i     = 32'h50;
        instr_i  = instr_of(32'h50);
        arm_i    = 1'b1;
        retire_i = 1'b1;
        tick();
        arm_i    = 1'b0;
        retire_i = 1'b0;
        check("armret_count", count_o, 7'd0);
        check("armret_state", state_o, 2'b01);
        check("armret_done", done_o, 1'b0);

        // RAM access fields.
        trig_en_i = 1'b0;
        retire_mem(32'h60, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF);
        retire_mem(32'h64, 1'b0, 1'b1, 32'h200, 32'h1234_5678);
        rd_idx_i = 6'd0;
        tick();
        check("mem0_pc", rd_pc_o, 32'h60);
`ifdef SVAROG_TRACE_MEM_EN
        check("mem0_flags", rd_flags_o, 2'b10);
        check("mem0_addr", rd_mem_addr_o, 32'h100);
        check("mem0_data", rd_mem_data_o, 32'hDEAD_BEEF);
`else
        check("mem0_flags", rd_flags_o, 2'b00);
        check("mem0_addr", rd_mem_addr_o, 32'h0);
        check("mem0_data", rd_mem_data_o, 32'h0);
`endif
        rd_idx_i = 6'd1;
        tick();
        check("mem1_pc", rd_pc_o, 32'h64);
`ifdef SVAROG_TRACE_MEM_EN
        check("mem1_flags", rd_flags_o, 2'b01);
        check("mem1_addr", rd_mem_addr_o, 32'h200);
        check("mem1_data", rd_mem_data_o, 32'h1234_5678);
`else
        check("mem1_flags", rd_flags_o, 2'b00);
        check("mem1_addr", rd_mem_addr_o, 32'h0);
        check("mem1_data", rd_mem_data_o, 32'h0);
`endif

        // Reset in POST with ten entries aborts immediately.
        trig_pc_i    = 32'h24;
        trig_en_i    = 1'b1;
        post_count_i = 16'd100;
        arm();
        for (int i = 0; i < 10; i++) retire(32'(4 * i));
        check("prerst_state", state_o, 2'b10);
        check("prerst_count", count_o, 7'd10);
        reset_ni = 1'b0;
        #1;
        check("midrst_state", state_o, 2'b00);
        check("midrst_count", count_o, 7'd0);
        check("midrst_done", done_o, 1'b0);
        tick();
        reset_ni = 1'b1;
        rd_idx_i = 6'd0;
        tick();
        check("midrst_rd_pc", rd_pc_o, 32'h0);
        check("midrst_rd_instr", rd_instr_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
